// File: rtl/rx_frame_sequencer.sv
// rtl/rx_frame_sequencer.sv - RX header byte sequencer with one accept/drop verdict per frame
module rx_frame_sequencer #(
    parameter logic [15:0] TFTP_PORT = 16'd69,
    parameter logic [7:0]  HDR_LAST  = 8'd41
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic        rx_err,
    input  logic [7:0]  rx_data,
    input  logic [15:0] sess_port,
    output logic [7:0]  cnt,
    output logic        hdr_en,
    output logic        vld_o,
    input  logic        rdy_i,
    output logic        ok_o,
    output logic [2:0]  reason_o,
    output logic [15:0] dst_port_o,
    output logic [7:0]  overrun_o
);

    localparam logic [2:0] R_OK      = 3'd0;
    localparam logic [2:0] R_ETYPE   = 3'd1;
    localparam logic [2:0] R_IPHDR   = 3'd2;
    localparam logic [2:0] R_PROTO   = 3'd3;
    localparam logic [2:0] R_PORT    = 3'd4;
    localparam logic [2:0] R_SHORT   = 3'd5;
    localparam logic [2:0] R_ERR     = 3'd6;
    localparam logic [2:0] R_RESTART = 3'd7;

    typedef enum logic [1:0] {IDLE, HDR, BODY, DISCARD} state_t;

    state_t      state, state_nx, frame_st;
    logic [7:0]  idx, idx_nx;
    logic [2:0]  lreason, lreason_nx;
    logic [7:0]  port_hi, port_hi_nx;
    logic [15:0] port, port_nx;
    logic        gen;
    logic [2:0]  gen_reason;
    logic [15:0] gen_dst;
    logic        fail;
    logic [2:0]  fail_reason;
    logic [15:0] rx_port;
    logic        port_ok;

    // idx holds the index of the next byte; the sof byte is always index 0
    assign cnt     = (rx_valid && rx_sof) ? 8'd0 : idx;
    assign hdr_en  = rx_valid && ((state != IDLE) || rx_sof) && (cnt <= HDR_LAST);
    assign rx_port = {port_hi, rx_data};
    assign port_ok = (rx_port == TFTP_PORT) || ((sess_port != 16'd0) && (rx_port == sess_port));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 8'd0;
            lreason <= R_OK;
            port_hi <= 8'd0;
            port    <= 16'd0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            lreason <= lreason_nx;
            port_hi <= port_hi_nx;
            port    <= port_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        lreason_nx  = lreason;
        port_hi_nx  = port_hi;
        port_nx     = port;
        gen         = 1'b0;
        gen_reason  = R_OK;
        gen_dst     = port;
        frame_st    = state;
        fail        = 1'b0;
        fail_reason = R_OK;
        if (rx_valid && rx_sof) begin
            if (state != IDLE) begin
                gen        = 1'b1;
                gen_reason = R_RESTART;
            end
            frame_st   = HDR;
            port_hi_nx = 8'd0;
            port_nx    = 16'd0;
        end
        if (rx_valid && (frame_st != IDLE)) begin
            if (cnt == 8'd36) port_hi_nx = rx_data;
            if (cnt == 8'd37) port_nx = rx_port;
            if (frame_st == HDR) begin
                case (cnt)
                    8'd12:   if (rx_data != 8'h08) begin fail = 1'b1; fail_reason = R_ETYPE; end
                    8'd13:   if (rx_data != 8'h00) begin fail = 1'b1; fail_reason = R_ETYPE; end
                    8'd14:   if (rx_data != 8'h45) begin fail = 1'b1; fail_reason = R_IPHDR; end
                    8'd23:   if (rx_data != 8'h11) begin fail = 1'b1; fail_reason = R_PROTO; end
                    8'd37:   if (!port_ok)         begin fail = 1'b1; fail_reason = R_PORT;  end
                    default: ;
                endcase
            end
            // a one-byte frame starting over a live one only reports the restart
            if (rx_sof && rx_eof && (state != IDLE)) begin
                state_nx = IDLE;
                idx_nx   = 8'd0;
            end else if (rx_eof) begin
                gen      = 1'b1;
                gen_dst  = port_nx;
                state_nx = IDLE;
                idx_nx   = 8'd0;
                case (frame_st)
                    HDR:     gen_reason = fail ? fail_reason : R_SHORT;
                    DISCARD: gen_reason = lreason;
                    default: gen_reason = R_OK;
                endcase
                if (rx_err) gen_reason = R_ERR;
            end else begin
                idx_nx   = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
                state_nx = frame_st;
                if (frame_st == HDR) begin
                    if (fail) begin
                        state_nx   = DISCARD;
                        lreason_nx = fail_reason;
                    end else if (cnt == HDR_LAST) begin
                        state_nx = BODY;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_o      <= 1'b0;
            ok_o       <= 1'b0;
            reason_o   <= R_OK;
            dst_port_o <= 16'd0;
            overrun_o  <= 8'd0;
        end else if (gen) begin
            if (!vld_o || rdy_i) begin
                vld_o      <= 1'b1;
                ok_o       <= (gen_reason == R_OK);
                reason_o   <= gen_reason;
                dst_port_o <= gen_dst;
            end else if (overrun_o != 8'hFF) begin
                overrun_o <= overrun_o + 8'd1;
            end
        end else if (vld_o && rdy_i) begin
            vld_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb/tb_rx_frame_sequencer.sv - self-checking bench for rx_frame_sequencer
module tb_rx_frame_sequencer;

    localparam int HDR_LAST = 41;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [2:0]  reason;
        logic [15:0] dst;
        logic        ok;
    } verdict_t;
    typedef struct {
        int          len;
        logic [15:0] port;
        logic [15:0] sess;
        int          mi;
        logic [7:0]  mv;
        bit          err;
        logic        ok;
        logic [2:0]  reason;
        logic [15:0] dst;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid, rx_sof, rx_eof, rx_err, rdy_i;
    logic [7:0]  rx_data;
    logic [15:0] sess_port;
    logic [7:0]  cnt, overrun_o;
    logic        hdr_en, vld_o, ok_o;
    logic [2:0]  reason_o;
    logic [15:0] dst_port_o;

    int checks = 0;
    int errors = 0;

    bq_t         m_cur;
    bit          m_active;
    bit          m_vld;
    logic [2:0]  m_reason;
    logic [15:0] m_dst;
    int          m_ovr;
    verdict_t    seen[$];
    vec_t        vecs[15];

    always #5 clk = ~clk;

    rx_frame_sequencer dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
        .rx_err(rx_err), .rx_data(rx_data), .sess_port(sess_port), .cnt(cnt), .hdr_en(hdr_en),
        .vld_o(vld_o), .rdy_i(rdy_i), .ok_o(ok_o), .reason_o(reason_o),
        .dst_port_o(dst_port_o), .overrun_o(overrun_o)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level verdict: first failing header rule by byte position
    function automatic void predict(input bq_t b, input bit by_eof, input bit err,
                                    output logic [2:0] r, output logic [15:0] d);
        int n;
        n = b.size();
        d = (n >= 38) ? {b[36], b[37]} : 16'h0000;
        if (!by_eof)                                                      r = 3'd7;
        else if (err)                                                     r = 3'd6;
        else if (n > 12 && b[12] != 8'h08)                                r = 3'd1;
        else if (n > 13 && b[13] != 8'h00)                                r = 3'd1;
        else if (n > 14 && b[14] != 8'h45)                                r = 3'd2;
        else if (n > 23 && b[23] != 8'h11)                                r = 3'd3;
        else if (n > 37 && !(d == 16'd69 || (sess_port != 16'd0 && d == sess_port))) r = 3'd4;
        else if (n <= HDR_LAST + 1)                                       r = 3'd5;
        else                                                              r = 3'd0;
    endfunction

    function automatic bq_t make_frame(input int len, input logic [15:0] port,
                                       input int mi, input logic [7:0] mv);
        bq_t q;
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = 8'(i * 7 + 3);
            case (i)
                12: b = 8'h08;
                13: b = 8'h00;
                14: b = 8'h45;
                23: b = 8'h11;
                36: b = port[15:8];
                37: b = port[7:0];
                default: ;
            endcase
            if (i == mi) b = mv;
            q.push_back(b);
        end
        return q;
    endfunction

    function automatic bit rdy_rand(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model, check registered outputs
    task automatic cyc(input bit v, input bit s, input bit e, input bit er,
                       input logic [7:0] d, input bit r);
        logic [7:0]  ecnt;
        bit          g;
        logic [2:0]  gr;
        logic [15:0] gd;
        rx_valid = v; rx_sof = s; rx_eof = e; rx_err = er; rx_data = d; rdy_i = r;
        #1;
        if (v && s)        ecnt = 8'd0;
        else if (m_active) ecnt = (m_cur.size() > 255) ? 8'd255 : 8'(m_cur.size());
        else               ecnt = 8'd0;
        chk("cnt", cnt, ecnt);
        chk("hdr_en", hdr_en, v && (m_active || s) && (ecnt <= HDR_LAST));
        if (vld_o && rdy_i) seen.push_back('{reason_o, dst_port_o, ok_o});
        g = 1'b0; gr = 3'd0; gd = 16'd0;
        if (v) begin
            if (s) begin
                if (m_active) begin
                    predict(m_cur, 1'b0, 1'b0, gr, gd);
                    g = 1'b1;
                end
                m_cur.delete();
                m_active = 1'b1;
            end
            if (m_active) begin
                m_cur.push_back(d);
                if (e) begin
                    predict(m_cur, 1'b1, er, gr, gd);
                    g = 1'b1;
                    m_active = 1'b0;
                    m_cur.delete();
                end
            end
        end
        @(posedge clk);
        if (g) begin
            if (m_vld && !r) begin
                if (m_ovr != 255) m_ovr++;
            end else begin
                m_vld = 1'b1; m_reason = gr; m_dst = gd;
            end
        end else if (m_vld && r) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
        chk("vld_o", vld_o, m_vld);
        chk("overrun_o", overrun_o, m_ovr);
        if (m_vld) begin
            chk("ok_o", ok_o, m_reason == 3'd0);
            chk("reason_o", reason_o, m_reason);
            chk("dst_port_o", dst_port_o, m_dst);
        end
    endtask

    task automatic send_frame(input bq_t q, input bit with_eof, input bit err,
                              input int rdy_pct, input int gap_pct);
        for (int i = 0; i < q.size(); i++) begin
            bit last;
            last = with_eof && (i == q.size() - 1);
            while ($urandom_range(99) < gap_pct) cyc(0, 0, 0, 0, 8'h00, rdy_rand(rdy_pct));
            cyc(1, i == 0, last, err && last, q[i], rdy_rand(rdy_pct));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 0; rx_sof = 0; rx_eof = 0; rx_err = 0; rx_data = 8'h00; rdy_i = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_cnt", cnt, 0);
        chk("rst_hdr_en", hdr_en, 0);
        chk("rst_vld_o", vld_o, 0);
        chk("rst_ok_o", ok_o, 0);
        chk("rst_reason_o", reason_o, 0);
        chk("rst_dst_port_o", dst_port_o, 0);
        chk("rst_overrun_o", overrun_o, 0);
        reset = 1'b0;
        m_cur.delete(); m_active = 0; m_vld = 0; m_reason = 0; m_dst = 0; m_ovr = 0;
    endtask

    initial begin
        bq_t q;
        sess_port = 16'h0000;
        vecs[0]  = '{60,  16'h0045, 16'h0000, -1, 8'h00, 1'b0, 1'b1, 3'd0, 16'h0045};
        vecs[1]  = '{60,  16'h0045, 16'h0000, 13, 8'h06, 1'b0, 1'b0, 3'd1, 16'h0045};
        vecs[2]  = '{60,  16'h0045, 16'h0000, 12, 8'h86, 1'b0, 1'b0, 3'd1, 16'h0045};
        vecs[3]  = '{60,  16'h0045, 16'h0000, 14, 8'h46, 1'b0, 1'b0, 3'd2, 16'h0045};
        vecs[4]  = '{60,  16'h0045, 16'h0000, 23, 8'h06, 1'b0, 1'b0, 3'd3, 16'h0045};
        vecs[5]  = '{60,  16'h1234, 16'h1234, -1, 8'h00, 1'b0, 1'b1, 3'd0, 16'h1234};
        vecs[6]  = '{60,  16'h1234, 16'h0000, -1, 8'h00, 1'b0, 1'b0, 3'd4, 16'h1234};
        vecs[7]  = '{60,  16'h1234, 16'h1235, -1, 8'h00, 1'b0, 1'b0, 3'd4, 16'h1234};
        vecs[8]  = '{31,  16'h0045, 16'h0000, -1, 8'h00, 1'b0, 1'b0, 3'd5, 16'h0000};
        vecs[9]  = '{300, 16'h0045, 16'h0000, -1, 8'h00, 1'b0, 1'b1, 3'd0, 16'h0045};
        vecs[10] = '{60,  16'h0045, 16'h0000, -1, 8'h00, 1'b1, 1'b0, 3'd6, 16'h0045};
        vecs[11] = '{60,  16'h0045, 16'h0000, 13, 8'h06, 1'b1, 1'b0, 3'd6, 16'h0045};
        vecs[12] = '{1,   16'h0045, 16'h0000, -1, 8'h00, 1'b0, 1'b0, 3'd5, 16'h0000};
        vecs[13] = '{38,  16'h0045, 16'h0000, -1, 8'h00, 1'b0, 1'b0, 3'd5, 16'h0045};
        vecs[14] = '{38,  16'h0099, 16'h0000, -1, 8'h00, 1'b0, 1'b0, 3'd4, 16'h0099};

        do_reset();

        foreach (vecs[k]) begin
            sess_port = vecs[k].sess;
            seen.delete();
            send_frame(make_frame(vecs[k].len, vecs[k].port, vecs[k].mi, vecs[k].mv),
                       1'b1, vecs[k].err, 100, 0);
            repeat (2) cyc(0, 0, 0, 0, 8'h00, 1'b1);
            chk($sformatf("vec%0d_count", k), seen.size(), 1);
            if (seen.size() == 1) begin
                chk($sformatf("vec%0d_ok", k), seen[0].ok, vecs[k].ok);
                chk($sformatf("vec%0d_reason", k), seen[0].reason, vecs[k].reason);
                chk($sformatf("vec%0d_dst", k), seen[0].dst, vecs[k].dst);
            end
        end

        // sof at index 50 restarts the frame
        sess_port = 16'h0000;
        seen.delete();
        q = make_frame(50, 16'h0045, -1, 8'h00);
        send_frame(q, 1'b0, 1'b0, 100, 0);
        send_frame(make_frame(60, 16'h0045, -1, 8'h00), 1'b1, 1'b0, 100, 0);
        repeat (2) cyc(0, 0, 0, 0, 8'h00, 1'b1);
        chk("restart_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("restart_reason", seen[0].reason, 3'd7);
            chk("restart_ok", seen[0].ok, 1'b0);
            chk("restart_dst", seen[0].dst, 16'h0045);
            chk("after_restart_reason", seen[1].reason, 3'd0);
            chk("after_restart_ok", seen[1].ok, 1'b1);
        end

        // reset at index 20 drops the frame silently
        seen.delete();
        send_frame(make_frame(20, 16'h0045, -1, 8'h00), 1'b0, 1'b0, 100, 0);
        do_reset();
        repeat (5) cyc(0, 0, 0, 0, 8'h00, 1'b1);
        chk("reset_midframe_no_verdict", seen.size(), 0);

        // back-to-back frames with no ready: first verdict held, later ones counted
        do_reset();
        repeat (3) send_frame(make_frame(42, 16'h0045, -1, 8'h00), 1'b1, 1'b0, 0, 0);
        cyc(0, 0, 0, 0, 8'h00, 1'b0);
        chk("hold_overrun", overrun_o, 8'd2);
        chk("hold_vld", vld_o, 1'b1);
        chk("hold_reason", reason_o, 3'd5);
        chk("hold_dst", dst_port_o, 16'h0045);
        cyc(0, 0, 0, 0, 8'h00, 1'b1);
        chk("release_vld", vld_o, 1'b0);

        // randomized traffic against the frame-level model
        do_reset();
        for (int f = 0; f < 150; f++) begin
            int          len;
            int          mi;
            logic [15:0] port;
            logic [7:0]  mv;
            bit          trunc;
            bit          er;
            int          picks[6];
            picks = '{12, 13, 14, 23, 36, 37};
            if (!m_active) begin
                repeat ($urandom_range(3)) cyc(1, 0, 0, 0, 8'($urandom), rdy_rand(70));
                sess_port = ($urandom_range(1) == 1) ? 16'h1234 : 16'h0000;
            end
            len = $urandom_range(90, 1);
            if (m_active && len < 2) len = 2;
            case ($urandom_range(2))
                0:       port = 16'd69;
                1:       port = 16'h1234;
                default: port = 16'($urandom);
            endcase
            mi    = ($urandom_range(3) == 0) ? picks[$urandom_range(5)] : -1;
            mv    = 8'($urandom);
            trunc = ($urandom_range(9) == 0);
            er    = ($urandom_range(9) == 0);
            send_frame(make_frame(len, port, mi, mv), !trunc, er, 60, 15);
        end
        send_frame(make_frame(60, 16'd69, -1, 8'h00), 1'b1, 1'b0, 60, 0);
        repeat (4) cyc(0, 0, 0, 0, 8'h00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
